jtopl_eg_core: RTL and testbench

JTOPL_EG_CORE -- requirements
Module: jtopl_eg_core

---
 rtl/jtopl_eg_pkg.sv | 21 ++
 rtl/jtopl_eg_step.sv | 97 +++++++++
 rtl/jtopl_eg_core.sv | 96 +++++++++
 tb/tb_jtopl_eg_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_eg_pkg.sv
// Shared definitions for the envelope-generator core: state encodings,
// frame size and the constants used by rate and sustain-level decoding.
package jtopl_eg_pkg;

    localparam int SLOTS = 18;

    localparam logic [1:0] EG_ATTACK  = 2'd0;
    localparam logic [1:0] EG_DECAY   = 2'd1;
    localparam logic [1:0] EG_SUSTAIN = 2'd2;
    localparam logic [1:0] EG_RELEASE = 2'd3;

    localparam logic [4:0] SL_MAX   = 5'd31;
    localparam logic [5:0] RATE_MAX = 6'd63;
    localparam logic [9:0] ATT_MAX  = 10'h3FF;

    // Sustain code 15 maps to the bottom of the range rather than to 15<<5.
    function automatic logic [9:0] sus_thresh(input logic [3:0] sl);
        sus_thresh = (sl == 4'd15) ? {SL_MAX, 5'd0} : {1'b0, sl, 5'd0};
    endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// Combinational envelope step for one slot: picks the rate for the slot's
// state, decides whether this frame steps, and returns next att and state.
module jtopl_eg_step
    import jtopl_eg_pkg::*;
(
    input  logic [9:0]  att,
    input  logic [1:0]  state,
    input  logic        kon_prev,
    input  logic        keyon,
    input  logic [3:0]  ar,
    input  logic [3:0]  dr,
    input  logic [3:0]  rr,
    input  logic [3:0]  sl,
    input  logic        en_sus,
    input  logic        ksr,
    input  logic [3:0]  keycode,
    input  logic [10:0] cnt_low,
    output logic [9:0]  att_next,
    output logic [1:0]  state_next
);

    logic        kon_edge;
    logic [1:0]  op_state;
    logic [3:0]  code;
    logic [3:0]  ks;
    logic [6:0]  rate_sum;
    logic [5:0]  rate;
    logic [3:0]  shift;
    logic [10:0] mask;
    logic        step;
    logic [1:0]  inc_log;
    logic [10:0] dec;
    logic [10:0] sum;
    logic [9:0]  diff;
    logic [9:0]  att_calc;

    // Rate decode, step decision, attenuation arithmetic and state transition.
    always_comb begin
        kon_edge = keyon & ~kon_prev;
        // A key-on edge runs the attack arithmetic on the same pass, so a
        // fast attack reaches zero on the slot's very first output.
        op_state = kon_edge ? EG_ATTACK : state;

        code = 4'd0;
        case (op_state)
            EG_ATTACK:  code = ar;
            EG_DECAY:   code = dr;
            EG_SUSTAIN: code = en_sus ? 4'd0 : rr;
            default:    code = rr;
        endcase

        ks       = ksr ? keycode : {2'b00, keycode[3:2]};
        rate_sum = {1'b0, code, 2'b00} + {3'b000, ks};
        if (code == 4'd0)
            rate = 6'd0;
        else if (rate_sum > {1'b0, RATE_MAX})
            rate = RATE_MAX;
        else
            rate = rate_sum[5:0];

        // Slow rates step when the low (11 - r[5:2]) counter bits are zero;
        // shift is meaningless for r>=48, where every frame steps.
        shift = 4'd11 - rate[5:2];
        mask  = ~(11'h7FF << shift);
        step  = (rate != 6'd0) && ((rate >= 6'd48) || ((cnt_low & mask) == 11'd0));
        // For r>=48, r[5:2]-12 equals the low two bits of r[5:2].
        inc_log = (rate >= 6'd48) ? rate[3:2] : 2'd0;

        dec  = ({5'd0, att[9:4]} + 11'd1) << inc_log;
        sum  = {1'b0, att} + (11'd1 << inc_log);
        diff = att - dec[9:0];

        att_calc = att;
        if (op_state == EG_ATTACK) begin
            if (rate >= 6'd60)
                att_calc = 10'd0;
            else if (step)
                att_calc = (dec >= {1'b0, att}) ? 10'd0 : diff;
        end else if (step) begin
            att_calc = sum[10] ? ATT_MAX : sum[9:0];
        end

        att_next = att_calc;

        if (kon_edge)
            state_next = EG_ATTACK;
        else if (!keyon)
            state_next = EG_RELEASE;
        else if (state == EG_ATTACK && att_calc == 10'd0)
            state_next = EG_DECAY;
        else if (state == EG_DECAY && att_calc >= sus_thresh(sl))
            state_next = EG_SUSTAIN;
        else
            state_next = state;
    end

endmodule

// File: rtl/jtopl_eg_core.sv
// Time-multiplexed envelope generator: per-slot attenuation/state storage,
// slot and frame counters, registered outputs for the previous slot.
// cen qualifies every input for the current slot; eg_pure/eg_state are
// valid from the cycle after a cen cycle and hold while cen is low.
module jtopl_eg_core #(
    parameter int SLOTS = jtopl_eg_pkg::SLOTS,
    parameter int CNTW  = 15              // must be at least 11
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       zero,
    input  logic       keyon,
    input  logic [3:0] ar,
    input  logic [3:0] dr,
    input  logic [3:0] rr,
    input  logic [3:0] sl,
    input  logic       en_sus,
    input  logic       ksr,
    input  logic [3:0] keycode,
    output logic [9:0] eg_pure,
    output logic [1:0] eg_state
);
    import jtopl_eg_pkg::*;

    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [SW-1:0]   slot_cnt;
    logic [SW-1:0]   cur_slot;
    logic [CNTW-1:0] eg_cnt;

    logic [9:0] att_mem   [SLOTS];
    logic [1:0] state_mem [SLOTS];
    logic       kon_mem   [SLOTS];

    logic [9:0] att_cur;
    logic [1:0] state_cur;
    logic       kon_cur;
    logic [9:0] att_next;
    logic [1:0] state_next;

    // zero forces slot 0 on this very cycle so the frame realigns at once.
    assign cur_slot  = zero ? '0 : slot_cnt;
    assign att_cur   = att_mem[cur_slot];
    assign state_cur = state_mem[cur_slot];
    assign kon_cur   = kon_mem[cur_slot];

    jtopl_eg_step u_step (
        .att        (att_cur),
        .state      (state_cur),
        .kon_prev   (kon_cur),
        .keyon      (keyon),
        .ar         (ar),
        .dr         (dr),
        .rr         (rr),
        .sl         (sl),
        .en_sus     (en_sus),
        .ksr        (ksr),
        .keycode    (keycode),
        .cnt_low    (eg_cnt[10:0]),
        .att_next   (att_next),
        .state_next (state_next)
    );

    // Per-slot storage: read-modify-write of the current slot on each cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                att_mem[i]   <= ATT_MAX;
                state_mem[i] <= EG_RELEASE;
                kon_mem[i]   <= 1'b0;
            end
        end else if (cen) begin
            att_mem[cur_slot]   <= att_next;
            state_mem[cur_slot] <= state_next;
            kon_mem[cur_slot]   <= keyon;
        end
    end

    // Slot counter, frame counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            eg_cnt   <= '0;
            eg_pure  <= ATT_MAX;
            eg_state <= EG_RELEASE;
        end else if (cen) begin
            slot_cnt <= (cur_slot == SW'(SLOTS - 1)) ? '0 : cur_slot + 1'b1;
            if (zero)
                eg_cnt <= eg_cnt + 1'b1;
            eg_pure  <= att_next;
            eg_state <= state_next;
        end
    end

endmodule

// File: tb/tb_jtopl_eg_core.sv
// Bench for jtopl_eg_core: slot 0 is driven through directed envelope
// scenarios, the other slots stay keyed off with random rate codes.
module tb_jtopl_eg_core;
    import jtopl_eg_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       zero = 1'b0;
    logic       keyon = 1'b0;
    logic [3:0] ar = 4'd0, dr = 4'd0, rr = 4'd0, sl = 4'd0, keycode = 4'd0;
    logic       en_sus = 1'b0, ksr = 1'b0;
    logic [9:0] eg_pure;
    logic [1:0] eg_state;

    always #5 clk = ~clk;

    jtopl_eg_core #(.SLOTS(18), .CNTW(15)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .zero     (zero),
        .keyon    (keyon),
        .ar       (ar),
        .dr       (dr),
        .rr       (rr),
        .sl       (sl),
        .en_sus   (en_sus),
        .ksr      (ksr),
        .keycode  (keycode),
        .eg_pure  (eg_pure),
        .eg_state (eg_state)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [11:0] last_exp = {EG_RELEASE, 10'h3FF};
    int          checks = 0;
    int          passes = 0;
    bit          started = 1'b0;
    int          frame_no = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s @%0t: got state=%0d att=0x%03h, expected state=%0d att=0x%03h",
                     name, $time, act[11:10], act[9:0], exp[11:10], exp[9:0]);
    endtask

    // Monitor: a cen (or rst) cycle produces one output to pop; otherwise the
    // outputs must still show the last expected value.
    initial begin
        logic        v;
        logic [11:0] e;
        forever begin
            @(posedge clk);
            v = cen | rst;
            #1;
            if (started) begin
                if (v) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_output @%0t: got state=%0d att=0x%03h, expected nothing queued",
                                 $time, eg_state, eg_pure);
                    end else begin
                        e = exp_q.pop_front();
                        last_exp = e;
                        check("slot_out", {eg_state, eg_pure}, e);
                    end
                end else begin
                    check("hold", {eg_state, eg_pure}, last_exp);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required stimulus end");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic drive_slot(input logic z, input logic kon,
                              input logic [3:0] a_r, input logic [3:0] d_r,
                              input logic [3:0] r_r, input logic [3:0] s_l,
                              input logic es, input logic ks_i, input logic [3:0] kc,
                              input logic [11:0] e);
        if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            cen = 1'b0;
        end
        @(negedge clk);
        cen = 1'b1; zero = z; keyon = kon;
        ar = a_r; dr = d_r; rr = r_r; sl = s_l;
        en_sus = es; ksr = ks_i; keycode = kc;
        exp_q.push_back(e);
    endtask

    task automatic other_slots(input int n);
        for (int i = 0; i < n; i++)
            drive_slot(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)), {EG_RELEASE, 10'h3FF});
    endtask

    task automatic frame0(input logic kon, input logic [3:0] a_r, input logic [3:0] d_r,
                          input logic [3:0] r_r, input logic [3:0] s_l, input logic es,
                          input logic ks_i, input logic [3:0] kc,
                          input logic [1:0] st, input logic [9:0] at);
        drive_slot(1'b1, kon, a_r, d_r, r_r, s_l, es, ks_i, kc, {st, at});
        frame_no++;
        other_slots(17);
    endtask

    task automatic pulse_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; cen = 1'b1; zero = 1'b0;
            exp_q.push_back({EG_RELEASE, 10'h3FF});
        end
        @(negedge clk);
        rst = 1'b0; cen = 1'b0;
        frame_no = 0;
    endtask

    function automatic logic [9:0] sat8(input logic [9:0] a);
        sat8 = (a > 10'h3F7) ? 10'h3FF : a + 10'd8;
    endfunction

    // Hand-computed ar=12 (r=48) attack from 0x3FF: att -= (att>>4)+1 per frame.
    logic [9:0] atk [11] = '{10'd959, 10'd899, 10'd842, 10'd789, 10'd739, 10'd692,
                             10'd648, 10'd607, 10'd569, 10'd533, 10'd499};

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] a;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);                 // idle cycle: reset values on outputs

        // Keyed off: every slot silent and releasing.
        for (int f = 0; f < 3; f++)
            frame0(1'b0, 4'd15, 4'd15, 4'd15, 4'd2, 1'b1, 1'b0, 4'd0, EG_RELEASE, 10'h3FF);

        // Fast attack to 0, then decay +8/frame to sustain 0x040 and hold.
        frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd2, 1'b1, 1'b0, 4'd0, EG_ATTACK, 10'd0);
        frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd2, 1'b1, 1'b0, 4'd0, EG_DECAY, 10'd0);
        for (int k = 1; k < 8; k++)
            frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd2, 1'b1, 1'b0, 4'd0, EG_DECAY, 10'(8 * k));
        for (int k = 0; k < 3; k++)
            frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd2, 1'b1, 1'b0, 4'd0, EG_SUSTAIN, 10'h040);

        // Percussive: sustain keeps rising at rr and saturates at 0x3FF.
        a = 10'h040;
        for (int k = 0; k < 122; k++) begin
            a = sat8(a);
            frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd2, 1'b0, 1'b0, 4'd0, EG_SUSTAIN, a);
        end

        // Key off, re-attack, decay to sustain 0x100, then release from 0x100.
        frame0(1'b0, 4'd15, 4'd15, 4'd15, 4'd2, 1'b0, 1'b0, 4'd0, EG_RELEASE, 10'h3FF);
        frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_ATTACK, 10'd0);
        frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_DECAY, 10'd0);
        for (int k = 1; k < 32; k++)
            frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_DECAY, 10'(8 * k));
        frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_SUSTAIN, 10'h100);
        frame0(1'b1, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_SUSTAIN, 10'h100);
        frame0(1'b0, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_RELEASE, 10'h100);
        a = 10'h100;
        for (int k = 0; k < 97; k++) begin
            a = sat8(a);
            frame0(1'b0, 4'd15, 4'd15, 4'd15, 4'd8, 1'b1, 1'b0, 4'd0, EG_RELEASE, a);
        end

        // Key scaling: dr=11, keycode=15 -> r=47 (+1/frame) with ksr=0,
        // r=59 (+4/frame) with ksr=1; sustain code 15 keeps the bar at 0x3E0.
        frame0(1'b1, 4'd15, 4'd11, 4'd15, 4'd15, 1'b1, 1'b0, 4'd15, EG_ATTACK, 10'd0);
        frame0(1'b1, 4'd15, 4'd11, 4'd15, 4'd15, 1'b1, 1'b0, 4'd15, EG_DECAY, 10'd0);
        for (int k = 1; k <= 4; k++)
            frame0(1'b1, 4'd15, 4'd11, 4'd15, 4'd15, 1'b1, 1'b0, 4'd15, EG_DECAY, 10'(k));
        for (int k = 1; k <= 4; k++)
            frame0(1'b1, 4'd15, 4'd11, 4'd15, 4'd15, 1'b1, 1'b1, 4'd15, EG_DECAY, 10'(4 + 4 * k));

        // dr=10, keycode=0 -> r=40: steps only when eg_cnt is even.
        a = 10'd20;
        for (int k = 0; k < 6; k++) begin
            if (frame_no % 2 == 0)
                a = a + 10'd1;
            frame0(1'b1, 4'd15, 4'd10, 4'd15, 4'd15, 1'b1, 1'b0, 4'd0, EG_DECAY, a);
        end

        // Key off with dr=0 (no step), then release to 0x3FF at r=63.
        frame0(1'b0, 4'd15, 4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 4'd0, EG_RELEASE, a);
        for (int k = 0; k < 130; k++) begin
            a = sat8(a);
            frame0(1'b0, 4'd15, 4'd0, 4'd15, 4'd15, 1'b1, 1'b1, 4'd15, EG_RELEASE, a);
        end

        // Slow attack (ar=12) from 0x3FF, reset mid-frame near 0x200.
        for (int k = 0; k < 10; k++)
            frame0(1'b1, 4'd12, 4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 4'd0, EG_ATTACK, atk[k]);
        drive_slot(1'b1, 1'b1, 4'd12, 4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 4'd0, {EG_ATTACK, atk[10]});
        frame_no++;
        other_slots(4);
        pulse_reset(2);
        frame0(1'b1, 4'd12, 4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 4'd0, EG_ATTACK, atk[0]);
        frame0(1'b1, 4'd12, 4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 4'd0, EG_ATTACK, atk[1]);

        // ---------------- final report ----------------
        @(negedge clk);
        cen = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() == 0)
            passes++;
        else
            $display("FAIL queue_drain: %0d expected outputs never seen, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
